ft_out_serializer: RTL and testbench

Byte serializer between the `wishbone_master` response port and the FTDI transmit byte FIFO in the FT245 synchronous host interface. It accepts response words from the master over the `out_ready`/`out_en` handshake and emits each packet MSB-first as a byte stream: sync byte, status, address, then data words. It pulses `pkt_done` on the last byte so the FTDI side can raise SIWU and flush. It runs entirely in the `clk` domain; the FIFO performs the crossing to `ftdi_clk`.

---
 rtl/ft_out_serializer_if.sv | 64 ++++++
 rtl/ft_out_serializer.sv | 222 ++++++++++++++++++++++
 tb/tb_ft_out_serializer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_out_serializer_if.sv
// ---------------------------------------------------------------------------
// ft_out_serializer_if
//
// Purpose: bundles the response-word handshake from the wishbone master and
// the byte-stream side toward the FTDI TX byte FIFO used by ft_out_serializer.
//
// Signals:
//   out_ready      : serializer can accept a word from the master
//   out_en         : single-cycle word strobe from the master
//   out_status     : response status (first word of a packet only)
//   out_address    : response address (first word of a packet only)
//   out_data_count : data words in the packet (first word only, 0 means 1)
//   out_data       : data word, sampled on every accepted strobe
//   byte_wr_en     : registered write strobe to the TX byte FIFO
//   byte_data      : registered byte, valid while byte_wr_en is high
//   byte_full      : FIFO almost-full (always leaves one free slot)
//   pkt_done       : pulse with the final byte of a packet
//   busy           : packet in progress
//
// Modports:
//   slave  : the serializer's view
//   master : the environment's view (word source plus FIFO)
// ---------------------------------------------------------------------------
interface ft_out_serializer_if;
  logic        out_ready;
  logic        out_en;
  logic [31:0] out_status;
  logic [31:0] out_address;
  logic [27:0] out_data_count;
  logic [31:0] out_data;
  logic        byte_wr_en;
  logic [7:0]  byte_data;
  logic        byte_full;
  logic        pkt_done;
  logic        busy;

  modport slave (
    output out_ready,
    input  out_en,
    input  out_status,
    input  out_address,
    input  out_data_count,
    input  out_data,
    output byte_wr_en,
    output byte_data,
    input  byte_full,
    output pkt_done,
    output busy
  );

  modport master (
    input  out_ready,
    output out_en,
    output out_status,
    output out_address,
    output out_data_count,
    output out_data,
    input  byte_wr_en,
    input  byte_data,
    output byte_full,
    input  pkt_done,
    input  busy
  );
endinterface

// File: rtl/ft_out_serializer.sv
// ---------------------------------------------------------------------------
// ft_out_serializer
//
// Purpose: turns response words from the wishbone master into an MSB-first
// byte stream for the FT245 TX byte FIFO. Each packet is a sync byte, four
// status bytes, four address bytes, then four bytes per data word. pkt_done
// marks the final byte so the FTDI side can raise SIWU and flush. Everything
// runs on clk; the byte FIFO handles the crossing to ftdi_clk.
//
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : ft_out_serializer_if.slave (word handshake in, byte stream out)
//
// Parameter:
//   SYNC_BYTE : first byte of every response packet
// ---------------------------------------------------------------------------
module ft_out_serializer #(
  parameter logic [7:0] SYNC_BYTE = 8'hDC
) (
  input  logic                 clk,
  input  logic                 rst,
  ft_out_serializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    NEXT = 2'd3
  } state_t;

  state_t      state, state_n;

  // idx is the index of the next byte to be issued within HDR (0..8) or
  // within the current data word in DATA (0..3).
  logic [3:0]  idx, idx_n;
  logic [27:0] words_left, words_left_n;
  logic [31:0] status_q, status_n;
  logic [31:0] address_q, address_n;
  logic [31:0] data_q, data_n;

  logic        out_ready_q, out_ready_n;
  logic        wr_en_q, wr_en_n;
  logic [7:0]  byte_q, byte_n;
  logic        pkt_done_q, pkt_done_n;
  logic        busy_q, busy_n;

  logic        accept;
  logic [7:0]  hdr_byte;
  logic [7:0]  data_byte;

  // A word is only taken while the registered ready is visible to the master,
  // so a strobe during a packet (or in the drain cycle after the last byte of
  // a word) has no effect.
  assign accept = bus.out_en && out_ready_q;

  // Header byte selected by idx: sync byte, then status and address MSB first.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      4'd0:    hdr_byte = SYNC_BYTE;
      4'd1:    hdr_byte = status_q[31:24];
      4'd2:    hdr_byte = status_q[23:16];
      4'd3:    hdr_byte = status_q[15:8];
      4'd4:    hdr_byte = status_q[7:0];
      4'd5:    hdr_byte = address_q[31:24];
      4'd6:    hdr_byte = address_q[23:16];
      4'd7:    hdr_byte = address_q[15:8];
      4'd8:    hdr_byte = address_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Data byte selected by the low bits of idx, MSB first.
  always_comb begin
    data_byte = 8'h00;
    case (idx[1:0])
      2'd0:    data_byte = data_q[31:24];
      2'd1:    data_byte = data_q[23:16];
      2'd2:    data_byte = data_q[15:8];
      default: data_byte = data_q[7:0];
    endcase
  end

  // Next-state and next-output logic. All outputs are registered, so this
  // block decides what the FIFO will see in the following cycle. A byte is
  // issued whenever byte_full is low in the current cycle; the FIFO's spare
  // slot absorbs the write already on the bus when full rises.
  // out_ready is raised only from a cycle already spent in IDLE or NEXT, which
  // puts it one cycle after the last byte of a word rather than alongside it.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    words_left_n = words_left;
    status_n     = status_q;
    address_n    = address_q;
    data_n       = data_q;
    out_ready_n  = 1'b0;
    wr_en_n      = 1'b0;
    byte_n       = byte_q;
    pkt_done_n   = 1'b0;

    case (state)
      IDLE: begin
        out_ready_n = 1'b1;
        if (accept) begin
          status_n     = bus.out_status;
          address_n    = bus.out_address;
          data_n       = bus.out_data;
          words_left_n = (bus.out_data_count == 28'd0) ? 28'd1 : bus.out_data_count;
          out_ready_n  = 1'b0;
          state_n      = HDR;
          // The sync byte goes out straight from the accepting edge so it
          // lands in the very next cycle.
          if (!bus.byte_full) begin
            wr_en_n = 1'b1;
            byte_n  = SYNC_BYTE;
            idx_n   = 4'd1;
          end else begin
            idx_n   = 4'd0;
          end
        end
      end

      HDR: begin
        if (!bus.byte_full) begin
          wr_en_n = 1'b1;
          byte_n  = hdr_byte;
          if (idx == 4'd8) begin
            idx_n   = 4'd0;
            state_n = DATA;
          end else begin
            idx_n   = idx + 4'd1;
          end
        end
      end

      DATA: begin
        if (!bus.byte_full) begin
          wr_en_n = 1'b1;
          byte_n  = data_byte;
          if (idx == 4'd3) begin
            idx_n        = 4'd0;
            words_left_n = words_left - 28'd1;
            // words_left is never below 1 here, so 1 means this was the last
            // word of the packet.
            if (words_left == 28'd1) begin
              pkt_done_n = 1'b1;
              state_n    = IDLE;
            end else begin
              state_n    = NEXT;
            end
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end

      NEXT: begin
        out_ready_n = 1'b1;
        if (accept) begin
          // Follow-on words only carry data; header fields stay as latched.
          data_n      = bus.out_data;
          out_ready_n = 1'b0;
          state_n     = DATA;
          if (!bus.byte_full) begin
            wr_en_n = 1'b1;
            byte_n  = bus.out_data[31:24];
            idx_n   = 4'd1;
          end else begin
            idx_n   = 4'd0;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // busy stays up through the pkt_done cycle and drops on the one after.
    busy_n = (state_n != IDLE) || pkt_done_n;
  end

  // State and output registers. Reset abandons any packet in flight: all
  // outputs go quiet and out_ready returns one cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 4'd0;
      words_left  <= 28'd0;
      status_q    <= 32'd0;
      address_q   <= 32'd0;
      data_q      <= 32'd0;
      out_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      byte_q      <= 8'h00;
      pkt_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      words_left  <= words_left_n;
      status_q    <= status_n;
      address_q   <= address_n;
      data_q      <= data_n;
      out_ready_q <= out_ready_n;
      wr_en_q     <= wr_en_n;
      byte_q      <= byte_n;
      pkt_done_q  <= pkt_done_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.out_ready  = out_ready_q;
  assign bus.byte_wr_en = wr_en_q;
  assign bus.byte_data  = byte_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ft_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_ft_out_serializer
//
// Purpose: self-checking bench for ft_out_serializer. Single-word packets are
// table driven; multi-word, stall, ignored-strobe and reset cases are
// hand-written sequences. A negedge monitor records every written byte with
// its cycle number, plus pkt_done, out_ready rise and busy fall cycles.
// ---------------------------------------------------------------------------
module tb_ft_out_serializer;

  logic clk;
  logic rst;
  int   cyc;

  ft_out_serializer_if bus();

  ft_out_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]  status;
    logic [31:0]  address;
    logic [27:0]  count;
    logic [31:0]  data;
    logic [103:0] exp_bytes;
  } vec_t;

  vec_t vecs [3];

  logic [7:0] byte_cap [$];
  int         cyc_cap  [$];
  logic [7:0] exp_q    [$];
  int         done_count;
  int         done_cyc;
  int         ready_rise;
  int         busy_fall;
  logic       prev_ready;
  logic       prev_busy;

  int errors;
  int checks;

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor samples away from the active edge.
  initial begin
    prev_ready = 1'b0;
    prev_busy  = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.byte_wr_en === 1'b1) begin
      byte_cap.push_back(bus.byte_data);
      cyc_cap.push_back(cyc);
    end
    if (bus.pkt_done === 1'b1) begin
      done_count = done_count + 1;
      done_cyc   = cyc;
    end
    if (bus.out_ready === 1'b1 && prev_ready !== 1'b1) ready_rise = cyc;
    if (bus.busy !== 1'b1 && prev_busy === 1'b1) busy_fall = cyc;
    prev_ready = bus.out_ready;
    prev_busy  = bus.busy;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearCapture();
    byte_cap.delete();
    cyc_cap.delete();
    exp_q.delete();
    done_count = 0;
    done_cyc   = -1;
    ready_rise = -1;
    busy_fall  = -1;
  endtask

  task automatic waitReady(input string name);
    int k;
    k = 0;
    while (bus.out_ready !== 1'b1 && k < 60) begin
      tick(1);
      k++;
    end
    checkOutput({name, " ready"}, {31'd0, bus.out_ready}, 32'd1);
  endtask

  // Drives one word for one cycle; n returns the cycle in which it was sampled.
  task automatic applyStimulus(input logic [31:0] st, input logic [31:0] ad,
                               input logic [27:0] cnt, input logic [31:0] dat,
                               output int n);
    bus.out_status     = st;
    bus.out_address    = ad;
    bus.out_data_count = cnt;
    bus.out_data       = dat;
    bus.out_en         = 1'b1;
    n = cyc;
    tick(1);
    bus.out_en = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic compareStream(input string name);
    int n;
    checkOutput({name, " len"}, byte_cap.size(), exp_q.size());
    n = (byte_cap.size() < exp_q.size()) ? byte_cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s byte%0d", name, i), {24'd0, byte_cap[i]}, {24'd0, exp_q[i]});
  endtask

  function automatic int capCyc(input int i);
    if (i < cyc_cap.size()) return cyc_cap[i];
    return -1;
  endfunction

  initial begin
    int n, m;
    vec_t v;
    errors = 0;
    checks = 0;
    done_count = 0;
    done_cyc = -1;
    ready_rise = -1;
    busy_fall = -1;

    vecs[0] = '{32'h00000001, 32'h01000000, 28'd1, 32'hAABBCCDD,
                104'hDC_00000001_01000000_AABBCCDD};
    vecs[1] = '{32'h00000001, 32'h01000000, 28'd0, 32'hAABBCCDD,
                104'hDC_00000001_01000000_AABBCCDD};
    vecs[2] = '{32'hDEADBEEF, 32'h12345678, 28'd1, 32'h0F1E2D3C,
                104'hDC_DEADBEEF_12345678_0F1E2D3C};

    rst                = 1'b1;
    bus.out_en         = 1'b0;
    bus.out_status     = 32'd0;
    bus.out_address    = 32'd0;
    bus.out_data_count = 28'd0;
    bus.out_data       = 32'd0;
    bus.byte_full      = 1'b0;

    // Reset values, then out_ready one cycle after release.
    tick(2);
    checkOutput("rst out_ready", {31'd0, bus.out_ready}, 32'd0);
    checkOutput("rst byte_wr_en", {31'd0, bus.byte_wr_en}, 32'd0);
    checkOutput("rst byte_data", {24'd0, bus.byte_data}, 32'd0);
    checkOutput("rst pkt_done", {31'd0, bus.pkt_done}, 32'd0);
    checkOutput("rst busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    checkOutput("rst cycle out_ready", {31'd0, bus.out_ready}, 32'd0);
    tick(1);
    checkOutput("post rst out_ready", {31'd0, bus.out_ready}, 32'd1);

    // Table-driven single-word packets.
    for (int i = 0; i < 3; i++) begin
      v = vecs[i];
      clearCapture();
      waitReady($sformatf("vec%0d", i));
      applyStimulus(v.status, v.address, v.count, v.data, n);
      tick(16);
      for (int k = 0; k < 13; k++) exp_q.push_back(v.exp_bytes[103 - 8*k -: 8]);
      compareStream($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d first cyc", i), capCyc(0), n + 1);
      checkOutput($sformatf("vec%0d last cyc", i), capCyc(12), n + 13);
      checkOutput($sformatf("vec%0d done count", i), done_count, 1);
      checkOutput($sformatf("vec%0d done cyc", i), done_cyc, n + 13);
      checkOutput($sformatf("vec%0d ready rise", i), ready_rise, n + 14);
      checkOutput($sformatf("vec%0d busy fall", i), busy_fall, n + 14);
    end

    // Three-word packet, each word 2 cycles after out_ready rises; later
    // words carry different header fields that must be ignored.
    clearCapture();
    waitReady("multi w1");
    tick(2);
    applyStimulus(32'hCAFE0001, 32'h00A0B0C0, 28'd3, 32'h11111111, n);
    waitReady("multi w2");
    tick(2);
    applyStimulus(32'hFFFFFFFF, 32'hEEEEEEEE, 28'd7, 32'h22222222, m);
    tick(1);
    checkOutput("multi w2 first byte cyc", capCyc(13), m + 1);
    waitReady("multi w3");
    tick(2);
    applyStimulus(32'h12121212, 32'h34343434, 28'd9, 32'h33333333, m);
    tick(12);
    exp_q.push_back(8'hDC);
    pushWord(32'hCAFE0001);
    pushWord(32'h00A0B0C0);
    pushWord(32'h11111111);
    pushWord(32'h22222222);
    pushWord(32'h33333333);
    compareStream("multi");
    checkOutput("multi done count", done_count, 1);
    checkOutput("multi done on last", done_cyc, capCyc(20));
    checkOutput("multi w3 first byte cyc", capCyc(17), m + 1);

    // byte_full high for 5 cycles so the 4th header byte is held back.
    clearCapture();
    waitReady("stall");
    applyStimulus(32'h11223344, 32'h55667788, 28'd1, 32'h99AABBCC, n);
    tick(2);
    bus.byte_full = 1'b1;
    tick(5);
    bus.byte_full = 1'b0;
    tick(14);
    exp_q.push_back(8'hDC);
    pushWord(32'h11223344);
    pushWord(32'h55667788);
    pushWord(32'h99AABBCC);
    compareStream("stall");
    checkOutput("stall 3rd byte cyc", capCyc(2), n + 3);
    checkOutput("stall 4th byte cyc", capCyc(3), n + 9);
    checkOutput("stall last cyc", capCyc(12), n + 18);
    checkOutput("stall done cyc", done_cyc, n + 18);
    checkOutput("stall done count", done_count, 1);

    // out_en pulsed during the header must be ignored.
    clearCapture();
    waitReady("hdr strobe");
    applyStimulus(32'hA1A2A3A4, 32'hB1B2B3B4, 28'd1, 32'hC1C2C3C4, n);
    tick(2);
    applyStimulus(32'h5A5A5A5A, 32'h6B6B6B6B, 28'd2, 32'h7C7C7C7C, m);
    tick(24);
    exp_q.push_back(8'hDC);
    pushWord(32'hA1A2A3A4);
    pushWord(32'hB1B2B3B4);
    pushWord(32'hC1C2C3C4);
    compareStream("hdr strobe");
    checkOutput("hdr strobe done count", done_count, 1);
    checkOutput("hdr strobe done cyc", done_cyc, n + 13);

    // Reset after byte 6 of a two-word packet.
    clearCapture();
    waitReady("midrst");
    applyStimulus(32'h0BADF00D, 32'h00C0FFEE, 28'd2, 32'h01020304, n);
    tick(5);
    rst = 1'b1;
    tick(1);
    checkOutput("midrst cyc", cyc, n + 7);
    checkOutput("midrst out_ready", {31'd0, bus.out_ready}, 32'd0);
    checkOutput("midrst byte_wr_en", {31'd0, bus.byte_wr_en}, 32'd0);
    checkOutput("midrst byte_data", {24'd0, bus.byte_data}, 32'd0);
    checkOutput("midrst pkt_done", {31'd0, bus.pkt_done}, 32'd0);
    checkOutput("midrst busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    tick(1);
    checkOutput("midrst ready back", {31'd0, bus.out_ready}, 32'd1);
    tick(10);
    checkOutput("midrst bytes", byte_cap.size(), 6);
    checkOutput("midrst no done", done_count, 0);

    clearCapture();
    v = vecs[0];
    waitReady("after rst");
    applyStimulus(v.status, v.address, v.count, v.data, n);
    tick(16);
    for (int k = 0; k < 13; k++) exp_q.push_back(v.exp_bytes[103 - 8*k -: 8]);
    compareStream("after rst");
    checkOutput("after rst done count", done_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
